// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU command sequencer: op codes, FSM states and the
// queued command format.
package alu_seq_pkg;

    localparam int DATA_W = 16;
    localparam int RES_W  = DATA_W + 1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_SHL = 3'b010;
    localparam logic [2:0] OP_SHR = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_NOT = 3'b111;

    // ST_HALT is only reachable when ERR_HALT_EN is defined.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    typedef struct packed {
        logic [2:0]        op;
        logic              src;
        logic [DATA_W-1:0] x;
        logic [DATA_W-1:0] y;
    } cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; DEPTH must be a power of two so the pointers wrap
// for free. An occupancy counter one bit wider than the pointers tells full from empty.
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [W-1:0]           wdata_i,
    output logic [W-1:0]           rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // NOTE: storage has no reset; only the pointers and count define validity,
    // which keeps the array a plain RAM without a reset fan-out.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples
    // its inputs from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Queues ALU commands, issues them to an external combinational ALU and returns
// one registered result per command. Define ERR_HALT_EN to halt after an error result.
module alu_cmd_sequencer #(
    parameter int CMD_DEPTH = 4,
    parameter int DATA_W    = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic              cmd_src,
    input  logic [DATA_W-1:0] cmd_x,
    input  logic [DATA_W-1:0] cmd_y,
    output logic [DATA_W-1:0] alu_x,
    output logic [DATA_W-1:0] alu_y,
    output logic [2:0]        alu_op,
    input  logic [DATA_W:0]   alu_out,
    input  logic              alu_err,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W:0]   res_data,
    output logic              res_err,
    output logic [DATA_W:0]   acc_out,
    input  logic              acc_clr,
    output logic              err_sticky,
    input  logic              clr_err,
    output logic              busy
);

    import alu_seq_pkg::*;

    cmd_t                        fifo_wdata, fifo_rdata;
    logic                        fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [$clog2(CMD_DEPTH):0]  fifo_count;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] alu_x_q, alu_x_d, alu_y_q, alu_y_d;
    logic [2:0]        alu_op_q, alu_op_d;
    logic [DATA_W:0]   res_data_q, acc_q;
    logic              res_err_q, err_sticky_q, capture;

    assign fifo_wdata = '{op: cmd_op, src: cmd_src, x: cmd_x, y: cmd_y};
    assign fifo_push  = cmd_valid && cmd_ready;

    alu_cmd_fifo #(
        .DEPTH (CMD_DEPTH),
        .W     ($bits(cmd_t))
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (fifo_wdata),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // NOTE: every output of this block gets a default first so no path
    // through the case leaves one unassigned and infers a latch.
    always_comb begin
        state_d  = state_q;
        alu_x_d  = alu_x_q;
        alu_y_d  = alu_y_q;
        alu_op_d = alu_op_q;
        fifo_pop = 1'b0;
        capture  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    alu_op_d = fifo_rdata.op;
                    alu_y_d  = fifo_rdata.y;
                    // Chained operand comes from the accumulator as it stands now.
                    alu_x_d  = fifo_rdata.src ? acc_q[DATA_W-1:0] : fifo_rdata.x;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                capture = 1'b1;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (res_ready) begin
`ifdef ERR_HALT_EN
                    state_d = res_err_q ? ST_HALT : ST_IDLE;
`else
                    state_d = ST_IDLE;
`endif
                end
            end
`ifdef ERR_HALT_EN
            ST_HALT: begin
                if (clr_err) state_d = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            alu_x_q      <= '0;
            alu_y_q      <= '0;
            alu_op_q     <= '0;
            res_data_q   <= '0;
            res_err_q    <= 1'b0;
            acc_q        <= '0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            alu_x_q  <= alu_x_d;
            alu_y_q  <= alu_y_d;
            alu_op_q <= alu_op_d;
            if (capture) begin
                res_data_q <= alu_out;
                res_err_q  <= alu_err;
            end
            // A clear beats a coincident capture; a new error beats a coincident clr_err.
            if (acc_clr) begin
                acc_q <= '0;
            end else if (capture && !alu_err) begin
                acc_q <= alu_out;
            end
            if (capture && alu_err) begin
                err_sticky_q <= 1'b1;
            end else if (clr_err) begin
                err_sticky_q <= 1'b0;
            end
        end
    end

    assign cmd_ready  = !fifo_full;
    assign alu_x      = alu_x_q;
    assign alu_y      = alu_y_q;
    assign alu_op     = alu_op_q;
    assign res_valid  = (state_q == ST_RESP);
    assign res_data   = res_data_q;
    assign res_err    = res_err_q;
    assign acc_out    = acc_q;
    assign err_sticky = err_sticky_q;
    assign busy       = (fifo_count != '0) || (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural ALU16bit stand-in;
// the ALU clears its output and flags an error on add carry-out or sub borrow.
module tb_alu_cmd_sequencer;

    import alu_seq_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = '0;
    logic        cmd_src = 1'b0;
    logic [15:0] cmd_x = '0;
    logic [15:0] cmd_y = '0;
    logic [15:0] alu_x, alu_y;
    logic [2:0]  alu_op;
    logic [16:0] alu_out;
    logic        alu_err;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [16:0] res_data;
    logic        res_err;
    logic [16:0] acc_out;
    logic        acc_clr = 1'b0;
    logic        err_sticky;
    logic        clr_err = 1'b0;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [16:0] alu_sum;

    alu_cmd_sequencer #(.CMD_DEPTH(4), .DATA_W(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_src    (cmd_src),
        .cmd_x      (cmd_x),
        .cmd_y      (cmd_y),
        .alu_x      (alu_x),
        .alu_y      (alu_y),
        .alu_op     (alu_op),
        .alu_out    (alu_out),
        .alu_err    (alu_err),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_err    (res_err),
        .acc_out    (acc_out),
        .acc_clr    (acc_clr),
        .err_sticky (err_sticky),
        .clr_err    (clr_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        alu_out = '0;
        alu_err = 1'b0;
        alu_sum = {1'b0, alu_x} + {1'b0, alu_y};
        case (alu_op)
            3'b000:  if (alu_sum[16]) alu_err = 1'b1; else alu_out = alu_sum;
            3'b001:  if (alu_x < alu_y) alu_err = 1'b1; else alu_out = {1'b0, alu_x - alu_y};
            3'b010:  alu_out = {alu_x, 1'b0};
            3'b011:  alu_out = {2'b00, alu_x[15:1]};
            3'b100:  alu_out = {1'b0, alu_x & alu_y};
            3'b101:  alu_out = {1'b0, alu_x | alu_y};
            3'b110:  alu_out = {1'b0, alu_x ^ alu_y};
            default: alu_out = {1'b0, ~alu_x};
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the accepting edge.
    task automatic push(input logic [2:0] op, input logic src, input logic [15:0] x,
                        input logic [15:0] y);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_src   = src;
        cmd_x     = x;
        cmd_y     = y;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) check("push_timeout", 32'd0, 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic collect(input logic [16:0] exp_d, input logic exp_e, input string tag);
        int n = 0;
        while (!res_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 32'(res_valid), 32'd1);
        check({tag, "_data"}, 32'(res_data), 32'(exp_d));
        check({tag, "_err"}, 32'(res_err), 32'(exp_e));
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic pulse_clr_err();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_acc", 32'(acc_out), 32'd0);
        check("rst_res_data", 32'(res_data), 32'd0);
        check("rst_alu_x", 32'(alu_x), 32'd0);
        check("rst_sticky", 32'(err_sticky), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Single add: op registered one edge after accept, result two edges after.
        push(OP_ADD, 1'b0, 16'h0001, 16'h0002);
        check("add_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("add_alu_op", 32'(alu_op), 32'(OP_ADD));
        check("add_alu_x", 32'(alu_x), 32'h1);
        check("add_alu_y", 32'(alu_y), 32'h2);
        check("add_not_yet_valid", 32'(res_valid), 32'd0);
        @(negedge clk);
        check("add_valid_lat", 32'(res_valid), 32'd1);
        check("add_acc", 32'(acc_out), 32'h3);
        collect(17'h00003, 1'b0, "add");
        check("add_done", 32'(res_valid), 32'd0);

        // Chained shl: x comes from acc, cmd_x ignored.
        push(OP_SHL, 1'b1, 16'hABCD, 16'h0000);
        @(negedge clk);
        check("shl_alu_x", 32'(alu_x), 32'h3);
        check("shl_alu_op", 32'(alu_op), 32'(OP_SHL));
        collect(17'h00006, 1'b0, "shl");
        check("shl_acc", 32'(acc_out), 32'h6);

        // Overflowing add: error reported, acc kept, sticky set.
        push(OP_ADD, 1'b0, 16'h0001, 16'hFFFF);
        collect(17'h00000, 1'b1, "ovf");
        check("ovf_acc", 32'(acc_out), 32'h6);
        check("ovf_sticky", 32'(err_sticky), 32'd1);
        push(OP_ADD, 1'b0, 16'h0002, 16'h0003);
`ifdef ERR_HALT_EN
        repeat (4) @(negedge clk);
        check("halt_no_issue", 32'(res_valid), 32'd0);
        check("halt_busy", 32'(busy), 32'd1);
`endif
        pulse_clr_err();
        check("clr_sticky", 32'(err_sticky), 32'd0);
        collect(17'h00005, 1'b0, "after_err");
        check("after_err_acc", 32'(acc_out), 32'h5);

        // Backpressure: one command in the FSM plus four queued fills the block.
        push(OP_ADD, 1'b0, 16'h0005, 16'h0007);
        push(OP_SUB, 1'b0, 16'h0009, 16'h0004);
        push(OP_AND, 1'b0, 16'hF0F0, 16'hFF00);
        push(OP_OR,  1'b0, 16'h0F00, 16'h00F0);
        push(OP_XOR, 1'b0, 16'hFFFF, 16'h00FF);
        check("full_cmd_ready", 32'(cmd_ready), 32'd0);
        check("full_res_valid", 32'(res_valid), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = OP_NOT;
        cmd_x     = 16'h1234;
        repeat (3) @(negedge clk);
        check("full_still_blocked", 32'(cmd_ready), 32'd0);
        cmd_valid = 1'b0;
        collect(17'h0000C, 1'b0, "burst0");
        collect(17'h00005, 1'b0, "burst1");
        collect(17'h0F000, 1'b0, "burst2");
        collect(17'h00FF0, 1'b0, "burst3");
        collect(17'h0FF00, 1'b0, "burst4");
        repeat (5) @(negedge clk);
        check("burst_no_extra", 32'(res_valid), 32'd0);
        check("burst_idle", 32'(busy), 32'd0);
        check("burst_acc", 32'(acc_out), 32'h0FF00);

        // acc_clr on the capture edge wins over the capture.
        push(OP_ADD, 1'b0, 16'h0008, 16'h0008);
        @(negedge clk);
        acc_clr = 1'b1;
        @(negedge clk);
        acc_clr = 1'b0;
        check("clr_acc", 32'(acc_out), 32'h0);
        collect(17'h00010, 1'b0, "clr");

        // Reset while in ISSUE with two commands still queued.
        res_ready = 1'b0;
        push(OP_ADD, 1'b0, 16'h0001, 16'h0001);
        push(OP_OR,  1'b0, 16'h1234, 16'h0000);
        push(OP_XOR, 1'b0, 16'h00FF, 16'h000F);
        push(OP_NOT, 1'b0, 16'h0000, 16'h0000);
        collect(17'h00002, 1'b0, "pre_rst");
        @(negedge clk);
        check("pre_rst_issue_op", 32'(alu_op), 32'(OP_OR));
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("mid_rst_res_valid", 32'(res_valid), 32'd0);
        check("mid_rst_acc", 32'(acc_out), 32'd0);
        check("mid_rst_alu_op", 32'(alu_op), 32'd0);
        check("mid_rst_alu_x", 32'(alu_x), 32'd0);
        check("mid_rst_res_data", 32'(res_data), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        check("post_rst_no_stale", 32'(res_valid), 32'd0);
        check("post_rst_idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Command-driven controller that sequences the shared 16-bit ALU: it queues operation commands, issues each one to the ALU and captures the 17-bit result and error flag into an accumulator. It returns one result per command over a valid/ready handshake.
It sits between the requester (bench/CPU-style master) and the combinational ALU16bit, which is instantiated outside this block. Supports chaining, where operand x comes from the accumulator.

Parameters:
CMD_DEPTH, 4, command FIFO depth; power of two, minimum 2.
DATA_W, 16, ALU operand width; result width is DATA_W+1.

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  FIFO can accept (not full)
cmd_op  in  3  ALU op code: 000 add, 001 sub, 010 shl, 011 shr, 100 and, 101 or, 110 xor, 111 not
cmd_src  in  1  1: x operand = acc[15:0]; 0: x = cmd_x
cmd_x  in  16  operand x
cmd_y  in  16  operand y
alu_x  out  16  registered operand to ALU
alu_y  out  16  registered operand to ALU
alu_op  out  3  registered op to ALU
alu_out  in  17  ALU result
alu_err  in  1  ALU overflow/underflow flag
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_data  out  17  captured result
res_err  out  1  error for this result
acc_out  out  17  accumulator
acc_clr  in  1  clear accumulator
err_sticky  out  1  any error since last clr_err
clr_err  in  1  clear err_sticky (and the halt, if enabled)
busy  out  1  FIFO non-empty or state != IDLE

Behaviour:
- Reset values: alu_x/alu_y/alu_op/res_data/acc_out = 0; res_valid, res_err, err_sticky, busy = 0; FIFO empty; state IDLE. cmd_ready is combinational (!full), so it is 1 out of reset.
- Reset mid-operation discards FIFO contents and any pending result.
- Enqueue happens on an edge with cmd_valid && cmd_ready. Stores {op, src, x, y}.
  - cmd_src is resolved at issue time, not at enqueue time.
- FSM states: IDLE, ISSUE, RESP (plus HALT under the optional feature).
  - IDLE and FIFO non-empty: pop the head and register alu_op, alu_y, and alu_x (= acc_out[15:0] if src, else x) -> ISSUE.
  - ISSUE: one cycle for ALU settle. Then on the edge: res_data <= alu_out, res_err <= alu_err; acc_out <= alu_out if !alu_err, else unchanged -> RESP.
  - RESP: res_valid = 1 and held stable until an edge with res_ready; then -> IDLE. res_data/res_err hold until the next capture.
- Latency: with an idle block, res_valid rises 2 edges after the accepting edge. Maximum throughput is one result per 3 cycles.
- A simultaneous enqueue and pop in the same cycle is legal. Full blocks enqueue only; empty blocks pop only.
- Pointers wrap modulo CMD_DEPTH. An occupancy counter of width clog2(CMD_DEPTH)+1 distinguishes full from empty.
- acc_clr clears acc_out at the next edge. If it coincides with a capture, the clear wins.
- err_sticky is set on a capture with alu_err and cleared by clr_err. Set wins over a coincident clear.
- Op codes outside the list are impossible (3-bit field is full); no illegal-op handling is required.

Optional Feature:
ERR_HALT_EN.
- Defined: RESP with res_err = 1 transitions on handshake to HALT instead of IDLE. HALT pops nothing; the FIFO still accepts until full; busy = 1. clr_err returns the FSM to IDLE at the next edge.
- Undefined: HALT does not exist; errors are reported only through res_err/err_sticky, and processing continues.

Decomposition:
- Package alu_seq_pkg: op-code constants (OP_ADD..OP_NOT), FSM state enum, the command struct {op, src, x, y}, and RES_W = DATA_W+1.
- One sub-module, alu_cmd_fifo: parameterised synchronous FIFO with push/pop/full/empty/count and asynchronous active-low reset.
- FSM and accumulator stay in the top level.

Test Plan:
- Enqueue add x=0x0001 y=0x0002 src=0 -> alu_op=000 one edge later; res_valid 2 edges after accept; res_data=0x00003, res_err=0, acc_out=0x00003.
- Follow with shl src=1 (x ignored) -> alu_x=0x0003, res_data=0x00006, acc_out=0x00006.
- add x=0x0001 y=0xFFFF -> res_err=1, res_data=0x00000, acc_out unchanged, err_sticky=1. With ERR_HALT_EN, the next queued command is not issued until clr_err pulses.
- Hold res_ready=0 and push 6 commands -> 1 popped into the FSM plus 4 queued, and cmd_ready=0 after the 5th accept. Release res_ready -> all 5 results return in order, no loss or duplication.
- acc_clr asserted on the capture edge of an add result 0x00010 -> acc_out=0, res_data=0x00010.
- Assert reset_n=0 while in ISSUE with 2 queued commands -> immediately all outputs 0, busy=0, cmd_ready=1. After release, no stale result appears.
